mix_columns_pipe: RTL and testbench
===================================

MIX_COLUMNS_PIPE -- requirements
Module: mix_columns_pipe

Interface
REQ-001 The block SHALL have parameter COLS_PER_CYCLE, default 1: columns processed per cycle; legal values 1, 2, 4.
REQ-002 The block SHALL have parameter INV_EN, default 1: 1 builds InvMixColumns logic; 0 removes it and treats inv_in as 0.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 in_valid  input  1  state, key, rcon and mode present.
REQ-006 in_ready  output  1  block can accept a new block.
REQ-007 state_in  input  128  AES state; byte 0 = [127:120]; column c = bytes 4c..4c+3.
REQ-008 key_in  input  128  round key, carried with the state.
REQ-009 rcon_in  input  8  round constant, carried and advanced.
REQ-010 inv_in  input  1  0 = MixColumns, 1 = InvMixColumns.
REQ-011 bypass_in  input  1  1 = final round: state passes through unmixed.
REQ-012 out_valid  output  1  result is valid.
REQ-013 out_ready  input  1  downstream accepts the result.
REQ-014 state_out  output  128  mixed state, same byte order as state_in.
REQ-015 key_out  output  128  key_in as captured.
REQ-016 rcon_out  output  8  xtime(rcon_in).

Function
REQ-017 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-018 In IDLE, in_ready SHALL be 1; a transfer SHALL occur when in_valid and in_ready are both 1 on a clock edge.
REQ-019 On a transfer, the block SHALL capture state, key, rcon, inv and bypass, clear the column counter, and go to BUSY.
REQ-020 In BUSY, each cycle SHALL transform COLS_PER_CYCLE columns, starting at column 0 and working in ascending order, in place.
REQ-021 The block SHALL go to DONE after 4/COLS_PER_CYCLE BUSY cycles, so out_valid rises that many cycles after the accept edge.
REQ-022 With bypass set, the block SHALL still spend the same BUSY cycles, but state_out SHALL equal state_in, keeping latency constant.
REQ-023 For MixColumns, with GF(2^8) polynomial 0x11B, each output column r SHALL be r0=2a0^3a1^a2^a3, r1=a0^2a1^3a2^a3, r2=a0^a1^2a2^3a3, r3=3a0^a1^a2^2a3.
REQ-024 For InvMixColumns, the coefficients SHALL be rows {0E,0B,0D,09} rotated per row.
REQ-025 xtime(x) SHALL be (x<<1)[7:0] when x[7]=0, and ((x<<1)[7:0])^0x1B when x[7]=1.
REQ-026 rcon_out SHALL be xtime of the captured rcon; e.g. 0x80 gives 0x1B.
REQ-027 In DONE, out_valid SHALL be 1, all outputs SHALL stay stable until out_ready is 1, and in_ready SHALL be 0.
REQ-028 When out_valid and out_ready are both 1 in DONE, the block SHALL return to IDLE; there is no same-cycle reload, and in_ready asserts on the next cycle.
REQ-029 in_valid in BUSY or DONE SHALL be ignored, with no capture.
REQ-030 An inv_in change after capture SHALL have no effect on the block in flight.

Reset
REQ-031 While rst_n is 0, the FSM SHALL be in IDLE, the counter 0, out_valid 0, in_ready 0, and state_out, key_out and rcon_out all zero.
REQ-032 in_ready SHALL rise on the first clock edge after rst_n deasserts.
REQ-033 Reset asserted mid-BUSY or mid-DONE SHALL abort the block immediately, with no partial output.

Structure
REQ-034 A shared package SHALL hold the GF polynomial constant 0x1B, the FSM state enum, and the function xtime.
REQ-035 A sub-module mix_column_unit SHALL implement one 32-bit column (forward/inverse) combinationally; it SHALL be instantiated COLS_PER_CYCLE times.
REQ-036 The inverse multiplies SHALL be built from chained xtime calls, with no lookup tables.

Verification
REQ-037 Forward, COLS_PER_CYCLE=1: column db135345 gives 8e4da1bc, and f20a225c gives 9fdc589d; out_valid rises 4 cycles after accept.
REQ-038 Inverse: column 8e4da1bc gives db135345; the full FIPS-197 round state round-trips to the original.
REQ-039 Rcon: 0x01 gives 0x02, 0x80 gives 0x1B, and 0x1B gives 0x36; key_out equals key_in bit-exact.
REQ-040 Backpressure: hold out_ready=0 for 10 cycles in DONE; outputs stay stable, in_ready stays 0, and a new in_valid is ignored.
REQ-041 Reset mid-BUSY (cycle 2): out_valid never rises, all outputs go to 0, and in_ready is 1 after release.
REQ-042 Sweep COLS_PER_CYCLE=2 and 4: results are identical, with latency 2 and 1 respectively; bypass returns state_in unchanged.

Source files
------------

// File: rtl/mix_columns_pipe_pkg.sv
// mix_columns_pipe_pkg: GF(2^8) constant, FSM states and field helpers shared by the MixColumns pipe
package mix_columns_pipe_pkg;
  localparam logic [7:0] GF_POLY = 8'h1B;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_t;
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? GF_POLY : 8'h00);
  endfunction
  // Multiply by a 4-bit constant as a sum of repeated doublings.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int b = 0; b < 4; b++) begin
      p ^= k[b] ? x : 8'h00;
      x = xtime(x);
    end
    return p;
  endfunction
endpackage

// File: rtl/mix_columns_pipe_if.sv
// mix_columns_pipe_if: valid/ready handshake bundle carrying the AES state, round key and rcon
// master drives in_valid/state_in/key_in/rcon_in/inv_in/bypass_in/out_ready;
// slave drives in_ready/out_valid/state_out/key_out/rcon_out.
interface mix_columns_pipe_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic [127:0] key_in;
  logic [7:0]   rcon_in;
  logic         inv_in;
  logic         bypass_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;
  logic [127:0] key_out;
  logic [7:0]   rcon_out;
  modport master (
    output in_valid, state_in, key_in, rcon_in, inv_in, bypass_in, out_ready,
    input  in_ready, out_valid, state_out, key_out, rcon_out
  );
  modport slave (
    input  in_valid, state_in, key_in, rcon_in, inv_in, bypass_in, out_ready,
    output in_ready, out_valid, state_out, key_out, rcon_out
  );
endinterface

// File: rtl/mix_column_unit.sv
// mix_column_unit: one 32-bit AES column through MixColumns or InvMixColumns, purely combinational
// i_col: column, byte 0 in [31:24]; i_inv: 1 selects the inverse matrix; o_col: mixed column.
module mix_column_unit import mix_columns_pipe_pkg::*; #(
  parameter bit INV_EN = 1
) (
  input  logic [31:0] i_col,
  input  logic        i_inv,
  output logic [31:0] o_col
);
  // First matrix row as nibbles; row r is this row rotated right by r.
  localparam logic [15:0] FWD = 16'h2311;
  localparam logic [15:0] INV = 16'hEBD9;
  logic w_inv;
  assign w_inv = INV_EN && i_inv;
  always_comb begin
    o_col = '0;
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 4; j++)
        o_col[31-8*r -: 8] ^= gmul(i_col[31-8*j -: 8],
          w_inv ? INV[15-4*((j-r+4)%4) -: 4] : FWD[15-4*((j-r+4)%4) -: 4]);
  end
endmodule

// File: rtl/mix_columns_pipe.sv
// mix_columns_pipe: captures one AES block and mixes COLS_PER_CYCLE columns per cycle in place
// clk, rst_n (async, active-low); bus: slave side of mix_columns_pipe_if.
module mix_columns_pipe import mix_columns_pipe_pkg::*; #(
  parameter int COLS_PER_CYCLE = 1,
  parameter bit INV_EN = 1
) (
  input logic            clk,
  input logic            rst_n,
  mix_columns_pipe_if.slave bus
);
  localparam int C = COLS_PER_CYCLE;
  localparam logic [1:0] LAST = 2'(4 / C - 1);
  fsm_t         r_fsm, w_fsm_nxt;
  logic [1:0]   r_cnt;
  logic [127:0] r_data, r_key, w_data_nxt;
  logic [7:0]   r_rcon;
  logic         r_inv, r_bypass, r_in_ready, w_take;
  logic [1:0]   w_idx [C];
  logic [31:0]  w_col [C];
  logic [31:0]  w_mix [C];
  assign w_take = bus.in_valid && r_in_ready;
  assign w_fsm_nxt = r_fsm == IDLE ? (w_take ? BUSY : IDLE) :
                     r_fsm == BUSY ? (r_cnt == LAST ? DONE : BUSY) :
                     (bus.out_ready ? IDLE : DONE);
  // Column c lives at bits [32*(3-c) +: 32]; ~idx is 3-c for a 2-bit index.
  for (genvar j = 0; j < C; j++) begin : g_col
    assign w_idx[j] = 2'(r_cnt * C + j);
    assign w_col[j] = r_data[{~w_idx[j], 5'd0} +: 32];
    mix_column_unit #(.INV_EN(INV_EN)) u_mix (
      .i_col(w_col[j]),
      .i_inv(r_inv),
      .o_col(w_mix[j])
    );
  end
  always_comb begin
    w_data_nxt = r_data;
    for (int j = 0; j < C; j++)
      w_data_nxt[{~w_idx[j], 5'd0} +: 32] = r_bypass ? w_col[j] : w_mix[j];
  end
  // in_ready is registered so it stays low through reset and rises one edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm      <= IDLE;
      r_cnt      <= '0;
      r_data     <= '0;
      r_key      <= '0;
      r_rcon     <= '0;
      r_inv      <= 1'b0;
      r_bypass   <= 1'b0;
      r_in_ready <= 1'b0;
    end else begin
      r_fsm      <= w_fsm_nxt;
      r_in_ready <= w_fsm_nxt == IDLE;
      if (w_take) begin
        r_data   <= bus.state_in;
        r_key    <= bus.key_in;
        r_rcon   <= xtime(bus.rcon_in);
        r_inv    <= INV_EN && bus.inv_in;
        r_bypass <= bus.bypass_in;
        r_cnt    <= '0;
      end else if (r_fsm == BUSY) begin
        r_data <= w_data_nxt;
        r_cnt  <= r_cnt + 2'd1;
      end
    end
  end
  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_fsm == DONE;
  assign bus.state_out = r_data;
  assign bus.key_out   = r_key;
  assign bus.rcon_out  = r_rcon;
endmodule

// File: tb/tb_mix_columns_pipe.sv
// tb_mix_columns_pipe: three pipes (1, 2, 4 columns per cycle) driven in lockstep against vectors and a GF model
module tb_mix_columns_pipe;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         inv_in = 1'b0;
  logic         bypass_in = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] state_in = '0;
  logic [127:0] key_in = '0;
  logic [7:0]   rcon_in = '0;
  logic         in_ready_a [3];
  logic         out_valid_a [3];
  logic [127:0] state_out_a [3];
  logic [127:0] key_out_a [3];
  logic [7:0]   rcon_out_a [3];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    mix_columns_pipe_if bus ();
    assign bus.in_valid  = in_valid;
    assign bus.state_in  = state_in;
    assign bus.key_in    = key_in;
    assign bus.rcon_in   = rcon_in;
    assign bus.inv_in    = inv_in;
    assign bus.bypass_in = bypass_in;
    assign bus.out_ready = out_ready;
    assign in_ready_a[k]  = bus.in_ready;
    assign out_valid_a[k] = bus.out_valid;
    assign state_out_a[k] = bus.state_out;
    assign key_out_a[k]   = bus.key_out;
    assign rcon_out_a[k]  = bus.rcon_out;
    mix_columns_pipe #(.COLS_PER_CYCLE(1 << k), .INV_EN(1)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
    );
  end

  typedef struct {
    logic [127:0] st;
    logic [127:0] key;
    logic [7:0]   rc;
    logic         inv;
    logic         byp;
    logic [127:0] es;
    logic [7:0]   er;
  } vec_t;
  vec_t vt [6];

  // Reference: schoolbook polynomial product reduced modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul_ref(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p ^= 16'(a) << i;
    for (int i = 15; i >= 8; i--) if (p[i]) p ^= 16'h011B << (i - 8);
    return p[7:0];
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] st, input logic inv, input logic byp);
    logic [7:0]   base [4];
    logic [127:0] r;
    if (byp) return st;
    if (inv) base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     base = '{8'h02, 8'h03, 8'h01, 8'h01};
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++)
        for (int j = 0; j < 4; j++)
          r[127-8*(4*c+row) -: 8] ^= gmul_ref(st[127-8*(4*c+j) -: 8], base[(j-row+4)%4]);
    return r;
  endfunction

  task automatic chk(input string nm, input int k, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cpc=%0d: got %h want %h", nm, 1 << k, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string nm);
    for (int k = 0; k < 3; k++) begin
      chk({nm, "_valid"}, k, out_valid_a[k], 0);
      chk({nm, "_ready"}, k, in_ready_a[k], 0);
      chk({nm, "_state"}, k, state_out_a[k], 0);
      chk({nm, "_key"}, k, key_out_a[k], 0);
      chk({nm, "_rcon"}, k, rcon_out_a[k], 0);
    end
  endtask

  task automatic run(input logic [127:0] st, input logic [127:0] key, input logic [7:0] rc,
                     input logic inv, input logic byp, input logic [127:0] es,
                     input logic [7:0] er, input int hold);
    for (int k = 0; k < 3; k++) chk("ready_pre", k, in_ready_a[k], 1);
    state_in = st; key_in = key; rcon_in = rc; inv_in = inv; bypass_in = byp;
    in_valid = 1'b1; out_ready = 1'b0;
    tick;
    in_valid = 1'b0;
    state_in = {$urandom(), $urandom(), $urandom(), $urandom()};
    key_in = ~key; rcon_in = ~rc; inv_in = ~inv;
    for (int c = 1; c <= 4; c++) begin
      tick;
      for (int k = 0; k < 3; k++) begin
        chk("valid_lat", k, out_valid_a[k], c >= (4 >> k));
        chk("busy_ready", k, in_ready_a[k], 0);
      end
    end
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      tick;
      for (int k = 0; k < 3; k++) begin
        chk("hold_valid", k, out_valid_a[k], 1);
        chk("hold_ready", k, in_ready_a[k], 0);
        chk("hold_state", k, state_out_a[k], es);
        chk("hold_key", k, key_out_a[k], key);
      end
    end
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("state", k, state_out_a[k], es);
      chk("key", k, key_out_a[k], key);
      chk("rcon", k, rcon_out_a[k], er);
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("post_valid", k, out_valid_a[k], 0);
      chk("post_ready", k, in_ready_a[k], 1);
    end
  endtask

  initial begin
    logic [127:0] st, key, es;
    logic [7:0]   rc, er;
    logic         inv, byp;
    vt[0] = '{128'hdb135345f20a225cd4d4d4d52d26314c, 128'h000102030405060708090a0b0c0d0e0f,
              8'h01, 1'b0, 1'b0, 128'h8e4da1bc9fdc589dd5d5d7d64d7ebdf8, 8'h02};
    vt[1] = '{128'h8e4da1bc9fdc589dd5d5d7d64d7ebdf8, 128'hfedcba98765432100123456789abcdef,
              8'h80, 1'b1, 1'b0, 128'hdb135345f20a225cd4d4d4d52d26314c, 8'h1b};
    vt[2] = '{128'hd4bf5d30e0b452aeb84111f11e2798e5, 128'h2b7e151628aed2a6abf7158809cf4f3c,
              8'h1b, 1'b0, 1'b0, 128'h046681e5e0cb199a48f8d37a2806264c, 8'h36};
    vt[3] = '{128'h046681e5e0cb199a48f8d37a2806264c, 128'ha0fafe1788542cb123a339392a6c7605,
              8'h36, 1'b1, 1'b0, 128'hd4bf5d30e0b452aeb84111f11e2798e5, 8'h6c};
    vt[4] = '{128'h00112233445566778899aabbccddeeff, 128'h0f0e0d0c0b0a09080706050403020100,
              8'h00, 1'b0, 1'b1, 128'h00112233445566778899aabbccddeeff, 8'h00};
    vt[5] = '{128'hffeeddccbbaa99887766554433221100, 128'h5555aaaa5555aaaa5555aaaa5555aaaa,
              8'h8d, 1'b1, 1'b1, 128'hffeeddccbbaa99887766554433221100, 8'h01};

    repeat (2) tick;
    chk_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) chk("rel_ready_early", k, in_ready_a[k], 0);
    tick;
    for (int k = 0; k < 3; k++) chk("rel_ready", k, in_ready_a[k], 1);

    for (int i = 0; i < 6; i++)
      run(vt[i].st, vt[i].key, vt[i].rc, vt[i].inv, vt[i].byp, vt[i].es, vt[i].er, 0);

    run(vt[0].st, vt[0].key, vt[0].rc, vt[0].inv, vt[0].byp, vt[0].es, vt[0].er, 10);

    repeat (16) begin
      st  = {$urandom(), $urandom(), $urandom(), $urandom()};
      key = {$urandom(), $urandom(), $urandom(), $urandom()};
      rc  = 8'($urandom());
      inv = 1'($urandom());
      byp = ($urandom_range(0, 5) == 0);
      es  = ref_mix(st, inv, byp);
      er  = gmul_ref(rc, 8'h02);
      run(st, key, rc, inv, byp, es, er, 0);
      if (!byp) run(es, key, er, ~inv, 1'b0, st, gmul_ref(er, 8'h02), 0);
    end

    state_in = vt[2].st; key_in = vt[2].key; rcon_in = vt[2].rc; inv_in = 1'b0; bypass_in = 1'b0;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    repeat (2) tick;
    chk("mid_busy_valid", 0, out_valid_a[0], 0);
    rst_n = 1'b0;
    #1;
    chk_zero("abort");
    repeat (2) begin
      tick;
      for (int k = 0; k < 3; k++) chk("abort_hold_valid", k, out_valid_a[k], 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    for (int k = 0; k < 3; k++) begin
      chk("abort_rel_ready", k, in_ready_a[k], 1);
      chk("abort_rel_valid", k, out_valid_a[k], 0);
    end
    run(vt[2].st, vt[2].key, vt[2].rc, vt[2].inv, vt[2].byp, vt[2].es, vt[2].er, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
